// File: rtl/mem_bus_arbiter.sv
// Two-master / one-slave arbiter for the 26-bit address / 32-bit data memory request bus.
// Define MEM_ARB_ROUND_ROBIN_EN to alternate grants on collisions; default is fixed priority to m0.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W       = 26,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned ACK_WAIT     = 2,
  parameter int unsigned DONE_TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_read_req,
  input  logic              m0_write_req,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_data_write,
  output logic [DATA_W-1:0] m0_data_read,
  output logic              m0_busy,
  input  logic              m1_read_req,
  input  logic              m1_write_req,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_data_write,
  output logic [DATA_W-1:0] m1_data_read,
  output logic              m1_busy,
  output logic              s_read_req,
  output logic              s_write_req,
  output logic [ADDR_W-1:0] s_addr,
  output logic [DATA_W-1:0] s_data_write,
  input  logic [DATA_W-1:0] s_data_read,
  input  logic              s_busy,
  output logic              timeout_err
);

  localparam logic [2:0] IDLE      = 3'd0;
  localparam logic [2:0] ISSUE     = 3'd1;
  localparam logic [2:0] WAIT_ACK  = 3'd2;
  localparam logic [2:0] WAIT_DONE = 3'd3;
  localparam logic [2:0] COMPLETE  = 3'd4;

  localparam logic [3:0] AckLimit  = 4'(ACK_WAIT);
  localparam logic [9:0] DoneLimit = 10'(DONE_TIMEOUT);

  logic [2:0]        state_q, state_d;
  logic              grant_q, grant_d;
  logic              pick;
  logic [1:0]        pending_q;
  logic [1:0]        hold_rnw_q;
  logic [ADDR_W-1:0] hold_addr0_q, hold_addr1_q;
  logic [DATA_W-1:0] hold_wdata0_q, hold_wdata1_q;
  logic [ADDR_W-1:0] s_addr_q;
  logic [DATA_W-1:0] s_wdata_q;
  logic [DATA_W-1:0] rdata0_q, rdata1_q;
  logic [3:0]        ack_cnt_q, ack_cnt_d;
  logic [9:0]        done_cnt_q, done_cnt_d;
  logic              timeout_q;
  logic              accept0, accept1;
  logic              load, complete, abort;
  logic              cur_rnw;

  assign accept0 = ~pending_q[0] & (m0_read_req | m0_write_req);
  assign accept1 = ~pending_q[1] & (m1_read_req | m1_write_req);
  assign cur_rnw = hold_rnw_q[grant_q];

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_q;

  always_comb begin
    pick = (&pending_q) ? ~last_grant_q : ~pending_q[0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      last_grant_q <= 1'b1;
    end else if (complete) begin
      last_grant_q <= grant_q;
    end
  end
`else
  always_comb begin
    pick = ~pending_q[0];
  end
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    ack_cnt_d  = ack_cnt_q;
    done_cnt_d = done_cnt_q;
    load       = 1'b0;
    complete   = 1'b0;
    abort      = 1'b0;
    case (state_q)
      IDLE: begin
        if (|pending_q) begin
          grant_d = pick;
          load    = 1'b1;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        ack_cnt_d = '0;
        state_d   = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (s_busy) begin
          done_cnt_d = '0;
          state_d    = WAIT_DONE;
        end else begin
          // Slave never raised busy: assume it finished without stalling.
          ack_cnt_d = ack_cnt_q + 4'd1;
          if (ack_cnt_d == AckLimit) state_d = COMPLETE;
        end
      end
      WAIT_DONE: begin
        if (!s_busy) begin
          state_d = COMPLETE;
        end else begin
          done_cnt_d = done_cnt_q + 10'd1;
          if (done_cnt_d == DoneLimit) begin
            abort   = 1'b1;
            state_d = COMPLETE;
          end
        end
      end
      COMPLETE: begin
        complete = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      grant_q    <= 1'b0;
      ack_cnt_q  <= '0;
      done_cnt_q <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      ack_cnt_q  <= ack_cnt_d;
      done_cnt_q <= done_cnt_d;
      if (abort) timeout_q <= 1'b1;
    end
  end

  // Holding registers keep each master's request stable while it waits for the slave.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending_q     <= '0;
      hold_rnw_q    <= '0;
      hold_addr0_q  <= '0;
      hold_addr1_q  <= '0;
      hold_wdata0_q <= '0;
      hold_wdata1_q <= '0;
    end else begin
      if (accept0) begin
        hold_addr0_q  <= m0_addr;
        hold_wdata0_q <= m0_data_write;
        hold_rnw_q[0] <= ~m0_write_req;
      end
      if (accept1) begin
        hold_addr1_q  <= m1_addr;
        hold_wdata1_q <= m1_data_write;
        hold_rnw_q[1] <= ~m1_write_req;
      end
      if (complete && !grant_q) pending_q[0] <= 1'b0;
      else if (accept0)         pending_q[0] <= 1'b1;
      if (complete && grant_q)  pending_q[1] <= 1'b0;
      else if (accept1)         pending_q[1] <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_addr_q  <= '0;
      s_wdata_q <= '0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      if (load) begin
        s_addr_q  <= grant_d ? hold_addr1_q : hold_addr0_q;
        s_wdata_q <= grant_d ? hold_wdata1_q : hold_wdata0_q;
      end
      if (complete && cur_rnw) begin
        if (grant_q) rdata1_q <= s_data_read;
        else         rdata0_q <= s_data_read;
      end
    end
  end

  assign s_read_req   = (state_q == ISSUE) &  cur_rnw;
  assign s_write_req  = (state_q == ISSUE) & ~cur_rnw;
  assign s_addr       = s_addr_q;
  assign s_data_write = s_wdata_q;
  assign m0_busy      = pending_q[0];
  assign m1_busy      = pending_q[1];
  assign m0_data_read = rdata0_q;
  assign m1_data_read = rdata1_q;
  assign timeout_err  = timeout_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: scripted scenarios plus randomized two-master traffic
// against a per-master memory model and a behavioural slave.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W       = 26;
  localparam int unsigned DATA_W       = 32;
  localparam int unsigned ACK_WAIT     = 2;
  localparam int unsigned DONE_TIMEOUT = 1023;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic              m0_read_req = 1'b0, m0_write_req = 1'b0;
  logic [ADDR_W-1:0] m0_addr = '0;
  logic [DATA_W-1:0] m0_data_write = '0;
  logic [DATA_W-1:0] m0_data_read;
  logic              m0_busy;
  logic              m1_read_req = 1'b0, m1_write_req = 1'b0;
  logic [ADDR_W-1:0] m1_addr = '0;
  logic [DATA_W-1:0] m1_data_write = '0;
  logic [DATA_W-1:0] m1_data_read;
  logic              m1_busy;
  logic              s_read_req, s_write_req;
  logic [ADDR_W-1:0] s_addr;
  logic [DATA_W-1:0] s_data_write;
  logic [DATA_W-1:0] s_data_read;
  logic              s_busy;
  logic              timeout_err;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ACK_WAIT(ACK_WAIT), .DONE_TIMEOUT(DONE_TIMEOUT)
  ) dut (
    .clk(clk), .reset(reset),
    .m0_read_req(m0_read_req), .m0_write_req(m0_write_req), .m0_addr(m0_addr),
    .m0_data_write(m0_data_write), .m0_data_read(m0_data_read), .m0_busy(m0_busy),
    .m1_read_req(m1_read_req), .m1_write_req(m1_write_req), .m1_addr(m1_addr),
    .m1_data_write(m1_data_write), .m1_data_read(m1_data_read), .m1_busy(m1_busy),
    .s_read_req(s_read_req), .s_write_req(s_write_req), .s_addr(s_addr),
    .s_data_write(s_data_write), .s_data_read(s_data_read), .s_busy(s_busy),
    .timeout_err(timeout_err)
  );

  // Behavioural slave: 32-word memory; busy rises the cycle after a strobe for cur_lat cycles.
  int                slave_mode = 0;     // 0 memory, 1 fixed value, 2 addr+0x100
  logic [DATA_W-1:0] slave_fixed = '0;
  int                slave_lat = 1;
  bit                slave_rand_lat = 1'b0;
  bit                slave_stuck = 1'b0;
  int                rand_lat = 0;
  int                cur_lat;
  int                scnt;
  logic [DATA_W-1:0] smem [32];
  logic [31:0]       swr;
  logic [ADDR_W-1:0] log_addr [$];
  logic [DATA_W-1:0] log_wdata [$];
  bit                log_rnw [$];

  // Reference model memory, updated in each master's program order.
  logic [DATA_W-1:0] exp_mem [32];
  logic [31:0]       exp_wr = '0;

  function automatic logic [DATA_W-1:0] init_val(input logic [4:0] i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  function automatic logic [DATA_W-1:0] exp_read(input logic [ADDR_W-1:0] a);
    return exp_wr[a[4:0]] ? exp_mem[a[4:0]] : init_val(a[4:0]);
  endfunction

  always_comb cur_lat = slave_rand_lat ? rand_lat : slave_lat;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      s_busy      <= 1'b0;
      scnt        <= 0;
      swr         <= '0;
      s_data_read <= '0;
    end else begin
      rand_lat <= int'($urandom_range(0, 4));
      if (s_read_req || s_write_req) begin
        log_addr.push_back(s_addr);
        log_wdata.push_back(s_data_write);
        log_rnw.push_back(s_read_req);
        if (slave_mode == 1)      s_data_read <= slave_fixed;
        else if (slave_mode == 2) s_data_read <= 32'(s_addr) + 32'h100;
        else if (s_read_req)
          s_data_read <= swr[s_addr[4:0]] ? smem[s_addr[4:0]] : init_val(s_addr[4:0]);
        if (s_write_req) begin
          smem[s_addr[4:0]] <= s_data_write;
          swr[s_addr[4:0]]  <= 1'b1;
        end
        if (slave_stuck || cur_lat > 0) s_busy <= 1'b1;
        scnt <= (cur_lat > 0) ? cur_lat - 1 : 0;
      end else if (scnt > 0) begin
        scnt <= scnt - 1;
      end else if (!slave_stuck) begin
        s_busy <= 1'b0;
      end
    end
  end

  function automatic logic [126:0] all_outs();
    return {m0_busy, m1_busy, s_read_req, s_write_req, timeout_err, s_addr, s_data_write,
            m0_data_read, m1_data_read};
  endfunction

  // Drive a one-cycle request from the negedge; afterwards scramble addr/data.
  task automatic drive(input int m, input bit rd, input bit wr,
                       input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    if (wr) begin
      exp_mem[a[4:0]] = d;
      exp_wr[a[4:0]]  = 1'b1;
    end
    if (m == 0) begin
      m0_read_req = rd; m0_write_req = wr; m0_addr = a; m0_data_write = d;
    end else begin
      m1_read_req = rd; m1_write_req = wr; m1_addr = a; m1_data_write = d;
    end
    @(negedge clk);
    if (m == 0) begin
      m0_read_req = 1'b0; m0_write_req = 1'b0;
      m0_addr = ADDR_W'($urandom); m0_data_write = $urandom;
    end else begin
      m1_read_req = 1'b0; m1_write_req = 1'b0;
      m1_addr = ADDR_W'($urandom); m1_data_write = $urandom;
    end
  endtask

  // Counts busy-high cycles from the current negedge, bounded by budget.
  task automatic wait_idle(input int m, input int budget, output int cycles);
    cycles = 0;
    while (((m == 0) ? m0_busy : m1_busy) && cycles <= budget) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 6; i++) begin
      m0_read_req = 1'($urandom); m0_write_req = 1'($urandom);
      m1_read_req = 1'($urandom); m1_write_req = 1'($urandom);
      m0_addr = ADDR_W'($urandom); m1_addr = ADDR_W'($urandom);
      m0_data_write = $urandom; m1_data_write = $urandom;
      @(negedge clk);
      vectors++;
      if (all_outs() !== '0) begin
        miscompares++;
        $display("FAIL reset_hold: outputs %h, expected 0", all_outs());
      end
    end
    m0_read_req = 1'b0; m0_write_req = 1'b0; m1_read_req = 1'b0; m1_write_req = 1'b0;
    exp_wr = '0;
    @(negedge clk);
    reset = 1'b1;
    repeat (3) @(negedge clk);
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++;
      $display("FAIL reset_release: outputs %h, expected 0", all_outs());
    end
  endtask

  task automatic test_single_read();
    int base, c;
    slave_mode = 1; slave_fixed = 32'hDEADBEEF; slave_lat = 3; slave_rand_lat = 1'b0;
    base = log_addr.size();
    drive(0, 1'b1, 1'b0, 26'h0000123, '0);
    // A strobe while busy must be ignored.
    m0_read_req = 1'b1; m0_addr = 26'h00003FF;
    @(negedge clk);
    m0_read_req = 1'b0;
    wait_idle(0, 50, c);
    c = c + 1;
    vectors++;
    if (c != 3 + 4) begin
      miscompares++; $display("FAIL single_busy_cycles: got %0d, expected %0d", c, 3 + 4);
    end
    vectors++;
    if (log_addr.size() != base + 1) begin
      miscompares++;
      $display("FAIL single_strobe_count: got %0d, expected %0d", log_addr.size() - base, 1);
    end else begin
      vectors++;
      if (log_addr[base] !== 26'h0000123 || log_rnw[base] !== 1'b1) begin
        miscompares++;
        $display("FAIL single_slave_req: got addr %h rnw %0d, expected 0000123 rnw 1",
                 log_addr[base], log_rnw[base]);
      end
    end
    vectors++;
    if (m0_data_read !== 32'hDEADBEEF) begin
      miscompares++; $display("FAIL single_rdata: got %h, expected deadbeef", m0_data_read);
    end
    vectors++;
    if (m1_busy !== 1'b0 || m1_data_read !== '0) begin
      miscompares++;
      $display("FAIL single_m1_untouched: got busy %b data %h, expected 0/0", m1_busy, m1_data_read);
    end
  endtask

  task automatic test_reset_mid();
    int base;
    slave_mode = 1; slave_fixed = 32'hCAFEF00D; slave_lat = 20;
    base = log_addr.size();
    drive(0, 1'b1, 1'b0, 26'h0000055, '0);
    repeat (4) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    vectors++;
    if (all_outs() !== '0) begin
      miscompares++; $display("FAIL reset_mid_async: outputs %h, expected 0", all_outs());
    end
    @(negedge clk);
    reset = 1'b1;
    exp_wr = '0;
    repeat (25) @(negedge clk);
    vectors++;
    if (m0_busy !== 1'b0 || m0_data_read !== '0 || log_addr.size() != base + 1) begin
      miscompares++;
      $display("FAIL reset_mid_dropped: got busy %b data %h strobes %0d, expected 0/0/1",
               m0_busy, m0_data_read, log_addr.size() - base);
    end
  endtask

  task automatic test_collision();
    int base, c;
    bit m1_first;
    logic [ADDR_W-1:0] a_first, a_second;
    logic [DATA_W-1:0] d_first, d_second;
    slave_mode = 0; slave_lat = 1;
    drive(0, 1'b0, 1'b1, 26'h0000005, 32'h0BADF00D);
    wait_idle(0, 50, c);
    base = log_addr.size();
    exp_mem[5'h10] = 32'h11111111; exp_wr[5'h10] = 1'b1;
    exp_mem[5'h00] = 32'h22222222; exp_wr[5'h00] = 1'b1;
    m0_write_req = 1'b1; m0_addr = 26'h10; m0_data_write = 32'h11111111;
    // m1 raises both strobes: must be treated as a write.
    m1_read_req = 1'b1; m1_write_req = 1'b1; m1_addr = 26'h20; m1_data_write = 32'h22222222;
    @(negedge clk);
    m0_write_req = 1'b0; m1_read_req = 1'b0; m1_write_req = 1'b0;
    c = 1;
    while ((m0_busy || m1_busy) && c <= 100) begin
      c++;
      @(negedge clk);
    end
    c = c - 1;
`ifdef MEM_ARB_ROUND_ROBIN_EN
    m1_first = 1'b1;
`else
    m1_first = 1'b0;
`endif
    a_first  = m1_first ? 26'h20 : 26'h10;
    a_second = m1_first ? 26'h10 : 26'h20;
    d_first  = m1_first ? 32'h22222222 : 32'h11111111;
    d_second = m1_first ? 32'h11111111 : 32'h22222222;
    vectors++;
    if (c != 2 * (1 + 4)) begin
      miscompares++; $display("FAIL collision_cycles: got %0d, expected %0d", c, 2 * (1 + 4));
    end
    vectors++;
    if (log_addr.size() != base + 2) begin
      miscompares++;
      $display("FAIL collision_count: got %0d, expected 2", log_addr.size() - base);
    end else begin
      vectors++;
      if (log_addr[base] !== a_first || log_wdata[base] !== d_first || log_rnw[base] !== 1'b0) begin
        miscompares++;
        $display("FAIL collision_first: got %h/%h rnw %0d, expected %h/%h rnw 0",
                 log_addr[base], log_wdata[base], log_rnw[base], a_first, d_first);
      end
      vectors++;
      if (log_addr[base+1] !== a_second || log_wdata[base+1] !== d_second ||
          log_rnw[base+1] !== 1'b0) begin
        miscompares++;
        $display("FAIL collision_second: got %h/%h rnw %0d, expected %h/%h rnw 0",
                 log_addr[base+1], log_wdata[base+1], log_rnw[base+1], a_second, d_second);
      end
    end
  endtask

  task automatic test_zero_latency();
    int c;
    logic [DATA_W-1:0] d;
    slave_mode = 0; slave_lat = 0;
    d = $urandom;
    drive(1, 1'b0, 1'b1, 26'h15, d);
    wait_idle(1, 50, c);
    vectors++;
    if (c != ACK_WAIT + 3) begin
      miscompares++; $display("FAIL zero_lat_write_cycles: got %0d, expected %0d", c, ACK_WAIT + 3);
    end
    drive(1, 1'b1, 1'b0, 26'h15, '0);
    wait_idle(1, 50, c);
    vectors++;
    if (c != ACK_WAIT + 3 || m1_data_read !== exp_read(26'h15)) begin
      miscompares++;
      $display("FAIL zero_lat_read: got %0d cycles data %h, expected %0d cycles data %h",
               c, m1_data_read, ACK_WAIT + 3, exp_read(26'h15));
    end
    drive(1, 1'b0, 1'b1, 26'h16, ~d);
    wait_idle(1, 50, c);
    vectors++;
    if (m1_data_read !== d || timeout_err !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_lat_hold: got data %h timeout %b, expected data %h timeout 0",
               m1_data_read, timeout_err, d);
    end
  endtask

  task automatic test_stuck();
    int c;
    logic [DATA_W-1:0] e;
    slave_mode = 0; slave_lat = 0; slave_stuck = 1'b1;
    e = exp_read(26'h07);
    drive(0, 1'b1, 1'b0, 26'h07, '0);
    wait_idle(0, DONE_TIMEOUT + 50, c);
    vectors++;
    if (c != DONE_TIMEOUT + 4) begin
      miscompares++; $display("FAIL stuck_cycles: got %0d, expected %0d", c, DONE_TIMEOUT + 4);
    end
    vectors++;
    if (timeout_err !== 1'b1 || m0_data_read !== e) begin
      miscompares++;
      $display("FAIL stuck_abort: got timeout %b data %h, expected 1/%h", timeout_err,
               m0_data_read, e);
    end
    slave_stuck = 1'b0;
    repeat (3) @(negedge clk);
    slave_lat = 2;
    e = exp_read(26'h18);
    drive(1, 1'b1, 1'b0, 26'h18, '0);
    wait_idle(1, 50, c);
    vectors++;
    if (c != 2 + 4 || m1_data_read !== e || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL stuck_recover: got %0d cycles data %h timeout %b, expected %0d/%h/1",
               c, m1_data_read, timeout_err, 2 + 4, e);
    end
  endtask

  task automatic test_back_to_back();
    int base, c;
    slave_mode = 2; slave_lat = 1;
    base = log_addr.size();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, 1'b0, ADDR_W'(i), '0);
      wait_idle(1, 50, c);
      vectors++;
      if (c != 1 + 4 || m1_data_read !== 32'h100 + 32'(i)) begin
        miscompares++;
        $display("FAIL b2b_read%0d: got %0d cycles data %h, expected %0d/%h", i, c,
                 m1_data_read, 1 + 4, 32'h100 + 32'(i));
      end
    end
    vectors++;
    if (log_addr.size() != base + 4) begin
      miscompares++;
      $display("FAIL b2b_strobes: got %0d, expected 4", log_addr.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        vectors++;
        if (log_addr[base+i] !== ADDR_W'(i) || log_rnw[base+i] !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_addr%0d: got %h rnw %0d, expected %h rnw 1", i,
                   log_addr[base+i], log_rnw[base+i], ADDR_W'(i));
        end
      end
    end
  endtask

  task automatic rand_master(input int m, input int nops);
    for (int i = 0; i < nops; i++) begin
      int kind, c;
      bit rd, wr;
      logic [ADDR_W-1:0] a;
      logic [DATA_W-1:0] d, e, got;
      repeat ($urandom_range(0, 3)) @(negedge clk);
      kind = int'($urandom_range(0, 3));
      rd = (kind <= 1) || (kind == 3);
      wr = (kind >= 2);
      a = ADDR_W'(m * 16 + int'($urandom_range(0, 15)));
      d = $urandom;
      e = exp_read(a);
      drive(m, rd, wr, a, d);
      wait_idle(m, 300, c);
      got = (m == 0) ? m0_data_read : m1_data_read;
      vectors++;
      if (c > 300) begin
        miscompares++; $display("FAIL rand_m%0d_op%0d: busy stuck for %0d cycles", m, i, c);
      end else if (!wr && got !== e) begin
        miscompares++;
        $display("FAIL rand_m%0d_op%0d: read %h got %h, expected %h", m, i, a, got, e);
      end
    end
  endtask

  task automatic test_random();
    int base;
    slave_mode = 0; slave_rand_lat = 1'b1;
    base = log_addr.size();
    fork
      rand_master(0, 25);
      rand_master(1, 25);
    join
    vectors++;
    if (log_addr.size() != base + 50 || timeout_err !== 1'b1) begin
      miscompares++;
      $display("FAIL rand_totals: got %0d strobes timeout %b, expected 50 timeout 1",
               log_addr.size() - base, timeout_err);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    @(negedge clk);
    test_reset();
    test_single_read();
    test_reset_mid();
    test_collision();
    test_zero_latency();
    test_stuck();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Two-master, one-slave arbiter on the 26-bit-address / 32-bit-data memory request bus between masters and hal.
- Master 0 is control_unit. Master 1 is a capture/DMA engine that writes ADC data into DDR.
- The slave port connects to the hal processor-interface memory port.
- Each master sees the same req/busy handshake as a private bus; requests are serialized and holding registers keep each master's transaction stable.

Parameters:
- ADDR_W, 26, address width.
- DATA_W, 32, data width.
- ACK_WAIT, 2, cycles after slave req to wait for s_busy to rise before treating the op as already complete (range 1..15).
- DONE_TIMEOUT, 1023, max cycles s_busy may stay high before forced abort (range 1..1023, counter 10 bits).

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted = 0)
- m0_read_req / m0_write_req  in  1  master 0 request strobes
- m0_addr  in  ADDR_W  master 0 address
- m0_data_write  in  DATA_W  master 0 write data
- m0_data_read  out  DATA_W  master 0 read data; valid when m0_busy falls
- m0_busy  out  1  master 0 transaction in flight
- m1_*  same six signals as m0_*, for master 1
- s_read_req / s_write_req  out  1  slave strobes, one-cycle pulses
- s_addr  out  ADDR_W  slave address
- s_data_write  out  DATA_W  slave write data
- s_data_read  in  DATA_W  slave read data
- s_busy  in  1  slave busy
- timeout_err  out  1  sticky; set on any DONE_TIMEOUT abort; cleared only by reset

Behaviour:
- Reset (reset=0, async):
  - FSM goes to IDLE; pending flags cleared.
  - All outputs 0: m*_busy, m*_data_read, s_*_req, s_addr, s_data_write, timeout_err.
  - An in-flight transaction is dropped; no completion is reported.
- Accept:
  - On an edge where mX_busy=0 and (mX_read_req | mX_write_req), latch addr, wdata and rnw into holding register X.
  - Set pendingX and mX_busy=1 on that edge.
  - Both strobes high: treated as a write.
  - Strobes while mX_busy=1: ignored.
- FSM states: IDLE, ISSUE, WAIT_ACK, WAIT_DONE, COMPLETE.
  - IDLE: if any pending, select grant by priority and move to ISSUE. s_addr/s_data_write load from the granted holding register on that edge. With nothing pending, stay in IDLE.
  - ISSUE: s_read_req or s_write_req high for exactly this one cycle. Go to WAIT_ACK and clear the ack counter.
  - WAIT_ACK:
    - s_busy=1: go to WAIT_DONE and clear the done counter.
    - Otherwise increment; when the count reaches ACK_WAIT, go to COMPLETE (zero-latency slave).
  - WAIT_DONE:
    - s_busy=0: go to COMPLETE.
    - Done counter reaching DONE_TIMEOUT: set timeout_err and go to COMPLETE. Read data is still whatever s_data_read holds.
  - COMPLETE: for a read, latch s_data_read into m{grant}_data_read on this edge. Clear pending{grant} and m{grant}_busy on this edge. Return to IDLE.
  - s_addr/s_data_write stay stable from ISSUE through COMPLETE. They hold their last value in IDLE.
- Default priority is fixed: master 0 wins simultaneous pending.
- Master 1 can starve under continuous master 0 traffic; this is accepted by design.
- A master may issue its next request the cycle after its busy falls. It is accepted on that edge and arbitrated on the next IDLE evaluation.
- m*_data_read holds until the next completed read for that master; writes do not change it.
- Latency: with a slave that raises s_busy one cycle after the strobe for N cycles, mX_busy stays high N+4 cycles when uncontended. Breakdown: accept edge, IDLE, ISSUE, WAIT_ACK, N in WAIT_DONE, COMPLETE.

Optional Feature:
- Macro: MEM_ARB_ROUND_ROBIN_EN.
- Defined: add a 1-bit last_grant register, reset to 1. On simultaneous pending, grant the master that is not last_grant. last_grant updates in COMPLETE. Each master waits at most one foreign transaction.
- Undefined: fixed priority to master 0; no last_grant register.

Test Plan:
- Reset: hold reset=0 with random inputs; release → all outputs 0, FSM IDLE. Assert reset mid-WAIT_DONE → m0_busy=0 and s strobes 0 immediately; no m0_data_read update.
- m0 single read: addr 0x0000123, slave busy 3 cycles, returns 0xDEADBEEF → exactly one s_read_req pulse with s_addr=0x0000123; m0_busy high 7 cycles; m0_data_read=0xDEADBEEF after fall; m1 untouched.
- Collision, fixed priority: m0 write 0x11111111 @0x10 and m1 write 0x22222222 @0x20 on the same edge → slave sees @0x10 then @0x20. Under MEM_ARB_ROUND_ROBIN_EN with last_grant=0 after reset-equivalent history → @0x20 first.
- Zero-latency slave: s_busy never rises → COMPLETE after ACK_WAIT=2 cycles; m1_busy high 5 cycles; timeout_err stays 0.
- Stuck slave: s_busy held high → abort after 1023 cycles in WAIT_DONE; timeout_err=1 and stays 1; m0_busy falls; a following m1 request is serviced normally.
- Back-to-back: m1 issues 4 reads to addrs 0..3 on successive busy falls, slave returns addr+0x100 → s_addr sequence 0,1,2,3 with no duplicate strobes; m1_data_read = 0x100..0x103 in order.
